// File: rtl/arbitro_enrutamiento_param.sv
// VC-to-destination arbiter/router: grants at most one VC per destination, pops it and
// pushes the routed word one cycle later. Define ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
module arbitro_enrutamiento_param #(
  parameter int DATA_W   = 6,
  parameter int NUM_VC   = 2,
  parameter int NUM_D    = 2,
  parameter int DEST_LSB = 4,
  parameter int CNT_W    = 5
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic [NUM_VC*DATA_W-1:0] vc_data,
  input  logic [NUM_VC-1:0]        vc_empty,
  input  logic [NUM_D-1:0]         d_full,
  input  logic [NUM_D-1:0]         d_almost_full,
  input  logic [NUM_D-1:0]         d_pause,
  output logic [NUM_VC-1:0]        vc_pop,
  output logic [NUM_D-1:0]         d_push,
  output logic [NUM_D*DATA_W-1:0]  d_data,
  output logic [NUM_D*CNT_W-1:0]   d_count,
  output logic                     idle
);

  localparam int DEST_W = $clog2(NUM_D);
  localparam int VC_W   = $clog2(NUM_VC);

  logic [DATA_W-1:0] word_s    [NUM_VC];
  logic [DEST_W-1:0] dest_s    [NUM_VC];
  logic [NUM_D-1:0]  blocked_s;
  logic [NUM_VC-1:0] req_s     [NUM_D];
  logic [NUM_VC-1:0] gnt_s     [NUM_D];
  logic [VC_W-1:0]   gnt_idx_s [NUM_D];
  logic [NUM_D-1:0]  gnt_any_s;
  logic [VC_W-1:0]   ptr_s     [NUM_D];
  logic [NUM_VC-1:0] pop_s;
  logic [DATA_W-1:0] d_data_r  [NUM_D];
  logic [CNT_W-1:0]  d_count_r [NUM_D];
  logic [NUM_D-1:0]  d_push_r;

  // Cyclic VC index: base + k wrapped into 0..NUM_VC-1 (both operands < NUM_VC).
  function automatic int vc_at(input int base, input int k);
    return (base + k >= NUM_VC) ? base + k - NUM_VC : base + k;
  endfunction

  for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
    assign word_s[gi] = vc_data[gi*DATA_W +: DATA_W];
    assign dest_s[gi] = word_s[gi][DEST_LSB +: DEST_W];
  end

  for (genvar gd = 0; gd < NUM_D; gd++) begin : g_dst
    assign blocked_s[gd]                  = d_full[gd] | d_almost_full[gd] | d_pause[gd];
    assign d_data[gd*DATA_W +: DATA_W]    = d_data_r[gd];
    assign d_count[gd*CNT_W +: CNT_W]     = d_count_r[gd];
  end

  // Request matrix: VC i asks destination j when non-empty, routed to j, and j is unblocked.
  always_comb begin
    for (int j = 0; j < NUM_D; j++) begin
      for (int i = 0; i < NUM_VC; i++) begin
        req_s[j][i] = ~vc_empty[i] & (dest_s[i] == DEST_W'(j)) & ~blocked_s[j];
      end
    end
  end

  // Per-destination grant: first requester scanning cyclically from the pointer.
  always_comb begin
    for (int j = 0; j < NUM_D; j++) begin
      gnt_s[j]     = {NUM_VC{1'b0}};
      gnt_idx_s[j] = {VC_W{1'b0}};
      gnt_any_s[j] = 1'b0;
      for (int k = 0; k < NUM_VC; k++) begin
        if (req_s[j][vc_at(int'(ptr_s[j]), k)] && !gnt_any_s[j]) begin
          gnt_s[j][vc_at(int'(ptr_s[j]), k)] = 1'b1;
          gnt_idx_s[j] = VC_W'(vc_at(int'(ptr_s[j]), k));
          gnt_any_s[j] = 1'b1;
        end else begin
          gnt_any_s[j] = gnt_any_s[j];
        end
      end
    end
  end

  // Each VC routes to exactly one destination, so OR-ing the grant vectors never collides.
  always_comb begin
    pop_s = {NUM_VC{1'b0}};
    for (int j = 0; j < NUM_D; j++) begin
      pop_s = pop_s | gnt_s[j];
    end
  end

  assign vc_pop = pop_s & {NUM_VC{reset_L}};
  assign d_push = d_push_r;
  assign idle   = (&vc_empty) & ~(|d_push_r);

  // Push stage: capture granted head word, raise push, bump wrapping counter.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      d_push_r <= {NUM_D{1'b0}};
      for (int j = 0; j < NUM_D; j++) begin
        d_data_r[j]  <= {DATA_W{1'b0}};
        d_count_r[j] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int j = 0; j < NUM_D; j++) begin
        if (gnt_any_s[j]) begin
          d_push_r[j]  <= 1'b1;
          d_data_r[j]  <= word_s[gnt_idx_s[j]];
          d_count_r[j] <= d_count_r[j] + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          d_push_r[j]  <= 1'b0;
          d_data_r[j]  <= d_data_r[j];
          d_count_r[j] <= d_count_r[j];
        end
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic [VC_W-1:0] rr_r [NUM_D];

  // Round-robin pointers: move just past the granted VC, hold otherwise.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int j = 0; j < NUM_D; j++) begin
        rr_r[j] <= {VC_W{1'b0}};
      end
    end else begin
      for (int j = 0; j < NUM_D; j++) begin
        if (gnt_any_s[j]) begin
          rr_r[j] <= VC_W'(vc_at(int'(gnt_idx_s[j]), 1));
        end else begin
          rr_r[j] <= rr_r[j];
        end
      end
    end
  end

  // Scan start follows the round-robin pointer.
  always_comb begin
    for (int j = 0; j < NUM_D; j++) begin
      ptr_s[j] = rr_r[j];
    end
  end
`else
  // Fixed priority: scan always starts at VC 0.
  always_comb begin
    for (int j = 0; j < NUM_D; j++) begin
      ptr_s[j] = {VC_W{1'b0}};
    end
  end
`endif

endmodule

// File: tb/tb_arbitro_enrutamiento_param.sv
// Scoreboard bench for arbitro_enrutamiento_param (default parameters); stimulus queues expected
// pushes, a monitor compares them one cycle later. Honours ARB_ROUND_ROBIN_EN.
module tb_arbitro_enrutamiento_param;

  logic        clk = 1'b0;
  logic        reset_L;
  logic [11:0] vc_data;
  logic [1:0]  vc_empty;
  logic [1:0]  d_full;
  logic [1:0]  d_almost_full;
  logic [1:0]  d_pause;
  logic [1:0]  vc_pop;
  logic [1:0]  d_push;
  logic [11:0] d_data;
  logic [9:0]  d_count;
  logic        idle;

  always #5 clk = ~clk;

  arbitro_enrutamiento_param #(
    .DATA_W(6), .NUM_VC(2), .NUM_D(2), .DEST_LSB(4), .CNT_W(5)
  ) dut (
    .clk(clk), .reset_L(reset_L), .vc_data(vc_data), .vc_empty(vc_empty),
    .d_full(d_full), .d_almost_full(d_almost_full), .d_pause(d_pause),
    .vc_pop(vc_pop), .d_push(d_push), .d_data(d_data), .d_count(d_count), .idle(idle)
  );

  typedef struct {
    logic [5:0] data;
    logic [4:0] cnt;
    int         cyc;
  } exp_t;

  exp_t       sbq [2][$];
  exp_t       mon_e;
  int         pass_cnt = 0;
  int         total_cnt = 0;
  int         cyc = 0;
  logic [4:0] exp_cnt [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pushed word must match the oldest expectation, in the expected cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int j = 0; j < 2; j++) begin
        if (sbq[j].size() > 0 && sbq[j][0].cyc == cyc) begin
          mon_e = sbq[j].pop_front();
          chk($sformatf("push%0d", j), {31'd0, d_push[j]}, 32'd1);
          chk($sformatf("data%0d", j), {26'd0, d_data[j*6 +: 6]}, {26'd0, mon_e.data});
          chk($sformatf("count%0d", j), {27'd0, d_count[j*5 +: 5]}, {27'd0, mon_e.cnt});
        end else if (d_push[j]) begin
          chk($sformatf("unexpected_push%0d", j), {31'd0, d_push[j]}, 32'd0);
        end
      end
    end
  end

  // Drive one cycle at the falling edge, check the combinational pop, queue the pushes it implies.
  task automatic step(input logic [1:0] empty, input logic [5:0] w0, input logic [5:0] w1,
                      input logic [1:0] full, input logic [1:0] af, input logic [1:0] pause,
                      input logic [1:0] exp_pop);
    logic [5:0] w;
    int         j;
    @(negedge clk);
    vc_empty      = empty;
    vc_data       = {w1, w0};
    d_full        = full;
    d_almost_full = af;
    d_pause       = pause;
    #1;
    chk("vc_pop", {30'd0, vc_pop}, {30'd0, exp_pop});
    for (int i = 0; i < 2; i++) begin
      if (exp_pop[i]) begin
        w = (i == 0) ? w0 : w1;
        j = int'(w[4]);
        exp_cnt[j] = exp_cnt[j] + 5'd1;
        sbq[j].push_back('{data: w, cnt: exp_cnt[j], cyc: cyc + 1});
      end
    end
  endtask

  logic [1:0] exp_c;
  logic [5:0] ww;

  initial begin
    reset_L = 1'b0;
    vc_empty = 2'b00; vc_data = {6'h1A, 6'h05};
    d_full = 2'b00; d_almost_full = 2'b00; d_pause = 2'b00;
    exp_cnt[0] = 5'd0; exp_cnt[1] = 5'd0;

    // Reset state: pops forced low even with requests present.
    @(negedge clk); #1;
    chk("rst_pop", {30'd0, vc_pop}, 32'd0);
    chk("rst_push", {30'd0, d_push}, 32'd0);
    chk("rst_count", {22'd0, d_count}, 32'd0);
    chk("rst_idle_busy", {31'd0, idle}, 32'd0);
    vc_empty = 2'b11; #1;
    chk("rst_idle", {31'd0, idle}, 32'd1);
    @(negedge clk); reset_L = 1'b1;

    // Routing: VC0 word 6'h13 goes to destination 1.
    step(2'b10, 6'h13, 6'h00, 2'b00, 2'b00, 2'b00, 2'b01);
    step(2'b11, 6'h00, 6'h00, 2'b00, 2'b00, 2'b00, 2'b00);
    chk("idle_push_inflight", {31'd0, idle}, 32'd0);
    step(2'b11, 6'h00, 6'h00, 2'b00, 2'b00, 2'b00, 2'b00);
    chk("idle_after", {31'd0, idle}, 32'd1);

    // Parallel: both destinations served in one cycle.
    step(2'b00, 6'h05, 6'h1A, 2'b00, 2'b00, 2'b00, 2'b11);

    // Contention on destination 0 for four cycles.
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_c = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
      exp_c = 2'b01;
`endif
      step(2'b00, 6'h02, 6'h07, 2'b00, 2'b00, 2'b00, exp_c);
    end

    // Backpressure: each blocking flag holds dest 0; dest 1 keeps flowing; release pops at once.
    step(2'b00, 6'h03, 6'h11, 2'b00, 2'b01, 2'b00, 2'b10);
    step(2'b00, 6'h03, 6'h11, 2'b00, 2'b00, 2'b01, 2'b10);
    step(2'b00, 6'h03, 6'h11, 2'b01, 2'b00, 2'b00, 2'b10);
    step(2'b00, 6'h03, 6'h11, 2'b00, 2'b00, 2'b00, 2'b11);
    step(2'b00, 6'h03, 6'h11, 2'b00, 2'b10, 2'b00, 2'b01);
    step(2'b11, 6'h00, 6'h00, 2'b00, 2'b00, 2'b00, 2'b00);

    // Reset mid-traffic: grant is dropped and outputs clear immediately.
    @(negedge clk);
    vc_empty = 2'b00; vc_data = {6'h1A, 6'h05}; #1;
    chk("pre_reset_pop", {30'd0, vc_pop}, 32'd3);
    reset_L = 1'b0; #1;
    chk("mid_rst_pop", {30'd0, vc_pop}, 32'd0);
    chk("mid_rst_count", {22'd0, d_count}, 32'd0);
    @(negedge clk); #1;
    chk("mid_rst_push", {30'd0, d_push}, 32'd0);
    chk("mid_rst_count2", {22'd0, d_count}, 32'd0);
    exp_cnt[0] = 5'd0; exp_cnt[1] = 5'd0;
    vc_empty = 2'b11; reset_L = 1'b1;
    step(2'b11, 6'h05, 6'h1A, 2'b00, 2'b00, 2'b00, 2'b00);
    chk("post_rst_push", {30'd0, d_push}, 32'd0);

    // Wrap: 32 pushes to destination 0 bring the counter back to 0.
    for (int i = 0; i < 32; i++) begin
      ww = 6'(i) & 6'h2F;
      step(2'b10, ww, 6'h3F, 2'b00, 2'b00, 2'b00, 2'b01);
    end
    step(2'b11, 6'h00, 6'h00, 2'b00, 2'b00, 2'b00, 2'b00);
    chk("wrap_count", {27'd0, d_count[4:0]}, 32'd0);
    chk("wrap_idle_busy", {31'd0, idle}, 32'd0);
    step(2'b11, 6'h00, 6'h00, 2'b00, 2'b00, 2'b00, 2'b00);
    chk("wrap_idle", {31'd0, idle}, 32'd1);

    step(2'b11, 6'h00, 6'h00, 2'b00, 2'b00, 2'b00, 2'b00);
    chk("sb_drained0", sbq[0].size(), 32'd0);
    chk("sb_drained1", sbq[1].size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
